// File: rtl/weight_bank.sv
// Multi-column signed weight store: streaming column-major loader and dual-port parallel read.
// Optional WBANK_INIT_FILE_EN resets into RUN so reads are served without a prior load.
module weight_bank #(
  parameter int unsigned NUM_COLS    = 10,
  parameter int unsigned DEPTH       = 784,
  parameter int unsigned DATA_W      = 8,
  parameter string       FILE_PREFIX = "weightCol",
  // One spare code beyond DEPTH so an out-of-range address is expressible at power-of-two depths
  localparam int unsigned AW         = $clog2(DEPTH + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       ld_start_i,
  input  logic                       ld_valid_i,
  input  logic [DATA_W-1:0]          ld_data_i,
  output logic                       ld_ready_o,
  output logic                       ld_done_o,
  input  logic                       rd_valid_i,
  input  logic [AW-1:0]              rd_addr1_i,
  input  logic [AW-1:0]              rd_addr2_i,
  output logic                       rd_ready_o,
  output logic                       out_valid_o,
  output logic [NUM_COLS*DATA_W-1:0] out_data1_o,
  output logic [NUM_COLS*DATA_W-1:0] out_data2_o,
  output logic                       rd_err_o
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;
`ifdef WBANK_INIT_FILE_EN
  localparam logic [1:0] StReset = StRun;
`else
  localparam logic [1:0] StReset = StIdle;
`endif

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] ld_addr_q, ld_addr_d;
  logic [CW-1:0] ld_col_q, ld_col_d;
  logic          ld_done_q, ld_done_d;

  logic ld_fire, rd_fire, last_addr, last_col;

  assign ld_ready_o = (state_q == StLoad);
  assign rd_ready_o = (state_q == StRun);
  assign ld_fire    = ld_valid_i & ld_ready_o;
  assign rd_fire    = rd_valid_i & rd_ready_o;
  assign last_addr  = (ld_addr_q == IW'(DEPTH - 1));
  assign last_col   = (ld_col_q == CW'(NUM_COLS - 1));
  assign ld_done_o  = ld_done_q;

  always_comb begin
    state_d   = state_q;
    ld_addr_d = ld_addr_q;
    ld_col_d  = ld_col_q;
    ld_done_d = 1'b0;
    case (state_q)
      StIdle, StRun: begin
        if (ld_start_i) begin
          state_d   = StLoad;
          ld_addr_d = '0;
          ld_col_d  = '0;
        end
      end
      StLoad: begin
        if (ld_fire) begin
          if (last_addr) begin
            ld_addr_d = '0;
            if (last_col) begin
              ld_col_d  = '0;
              ld_done_d = 1'b1;
              state_d   = StRun;
            end else begin
              ld_col_d = ld_col_q + CW'(1);
            end
          end else begin
            ld_addr_d = ld_addr_q + IW'(1);
          end
        end
      end
      default: state_d = StReset;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StReset;
      ld_addr_q <= '0;
      ld_col_q  <= '0;
      ld_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_addr_q <= ld_addr_d;
      ld_col_q  <= ld_col_d;
      ld_done_q <= ld_done_d;
    end
  end

  logic                       in_range1, in_range2;
  logic [IW-1:0]              idx1, idx2;
  logic [NUM_COLS*DATA_W-1:0] row1, row2;

  assign in_range1 = (rd_addr1_i < AW'(DEPTH));
  assign in_range2 = (rd_addr2_i < AW'(DEPTH));
  assign idx1      = rd_addr1_i[IW-1:0];
  assign idx2      = rd_addr2_i[IW-1:0];

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
      if (ld_fire && (ld_col_q == CW'(c))) begin
        mem[ld_addr_q] <= ld_data_i;
      end
    end

    // Out-of-range indices read garbage here; masked to zero at the output register
    assign row1[c*DATA_W +: DATA_W] = mem[idx1];
    assign row2[c*DATA_W +: DATA_W] = mem[idx2];
  end

  logic                       out_valid_q, rd_err_q;
  logic [NUM_COLS*DATA_W-1:0] out_data1_q, out_data2_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      rd_err_q    <= 1'b0;
      out_data1_q <= '0;
      out_data2_q <= '0;
    end else begin
      out_valid_q <= rd_fire;
      rd_err_q    <= rd_fire & ~(in_range1 & in_range2);
      if (rd_fire) begin
        out_data1_q <= in_range1 ? row1 : '0;
        out_data2_q <= in_range2 ? row2 : '0;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign rd_err_o    = rd_err_q;
  assign out_data1_o = out_data1_q;
  assign out_data2_o = out_data2_q;

endmodule

// File: tb/tb_weight_bank.sv
// Bench for weight_bank (2 columns x 4 words x 8 bits): directed steps then randomized reads.
module tb_weight_bank;
  localparam int NC = 2;
  localparam int D  = 4;
  localparam int W  = 8;
  localparam int AW = $clog2(D + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            ld_start = 1'b0, ld_valid = 1'b0;
  logic [W-1:0]    ld_data = '0;
  logic            ld_ready, ld_done;
  logic            rd_valid = 1'b0;
  logic [AW-1:0]   rd_addr1 = '0, rd_addr2 = '0;
  logic            rd_ready, out_valid, rd_err;
  logic [NC*W-1:0] out_data1, out_data2;

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] model [NC][D];
  logic [W-1:0] dat [NC*D];

  weight_bank #(.NUM_COLS(NC), .DEPTH(D), .DATA_W(W)) dut (
    .clk_i(clk), .rst_i(rst),
    .ld_start_i(ld_start), .ld_valid_i(ld_valid), .ld_data_i(ld_data),
    .ld_ready_o(ld_ready), .ld_done_o(ld_done),
    .rd_valid_i(rd_valid), .rd_addr1_i(rd_addr1), .rd_addr2_i(rd_addr2),
    .rd_ready_o(rd_ready), .out_valid_o(out_valid),
    .out_data1_o(out_data1), .out_data2_o(out_data2), .rd_err_o(rd_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got running, required finished)");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference row: every column at address a, zero when a is past the end
  function automatic logic [NC*W-1:0] exp_row(input int a);
    logic [NC*W-1:0] r = '0;
    if (a < D) for (int c = 0; c < NC; c++) r[c*W +: W] = model[c][a];
    return r;
  endfunction

  // Column-major stream of dat; optional one-cycle gap before beat gap_at; rst after stop_at beats
  task automatic load_seq(input int gap_at, input int stop_at);
    int  beats = 0;
    int  guard = 0;
    bit  gapped = 0;
    bit  acc;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    chk("ld_ready_in_load", ld_ready, 1);
    while (beats < NC*D) begin
      if (beats == stop_at) begin
        rst = 1'b1;
        #1;
        chk("ld_ready_on_rst", ld_ready, 0);
        chk("ld_done_on_rst", ld_done, 0);
        ld_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("idle_rd_ready", rd_ready, 0);
        chk("idle_ld_ready", ld_ready, 0);
        return;
      end
      if (beats == gap_at && !gapped) begin
        ld_valid = 1'b0;
        gapped = 1;
      end else begin
        ld_valid = 1'b1;
        ld_data  = dat[beats];
      end
      acc = ld_valid && ld_ready;
      tick();
      if (acc) begin
        model[beats / D][beats % D] = dat[beats];
        beats++;
      end
      if (beats < NC*D) chk("ld_done_early", ld_done, 0);
      guard++;
      if (guard > 64) begin
        n_chk++;
        n_fail++;
        $error("FAIL load_timeout: observed %0d beats expected %0d", beats, NC*D);
        ld_valid = 1'b0;
        return;
      end
    end
    ld_valid = 1'b0;
    chk("ld_done_pulse", ld_done, 1);
    chk("rd_ready_after_load", rd_ready, 1);
    chk("ld_ready_after_load", ld_ready, 0);
    tick();
    chk("ld_done_single", ld_done, 0);
  endtask

  task automatic rd(input int a1, input int a2);
    rd_valid = 1'b1;
    rd_addr1 = AW'(a1);
    rd_addr2 = AW'(a2);
    tick();
    rd_valid = 1'b0;
  endtask

  logic [NC*W-1:0] hold1, hold2, e1, e2;
  bit              pv, perr;

  initial begin
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_rd_ready", rd_ready, 0);
      chk("reset_ld_ready", ld_ready, 0);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_data1", out_data1, 0);
    end

    for (int i = 0; i < NC*D; i++) dat[i] = W'(i + 1);
    load_seq(3, -1);

    rd(2, 3);
    chk("rd23_valid", out_valid, 1);
    chk("rd23_data1", out_data1, 16'h0703);
    chk("rd23_data2", out_data2, 16'h0804);
    chk("rd23_err", rd_err, 0);

    rd_valid = 1'b1;
    for (int a = 0; a < 3; a++) begin
      rd_addr1 = AW'(a);
      rd_addr2 = AW'(a);
      tick();
      chk("b2b_valid", out_valid, 1);
      chk("b2b_data1", out_data1, {8'(a + 5), 8'(a + 1)});
      chk("b2b_data2", out_data2, {8'(a + 5), 8'(a + 1)});
    end
    rd_valid = 1'b0;
    tick();
    chk("b2b_valid_drop", out_valid, 0);
    chk("b2b_hold", out_data1, 16'h0703);

    rd(4, 0);
    chk("oor_data1", out_data1, 16'h0000);
    chk("oor_data2", out_data2, 16'h0501);
    chk("oor_err", rd_err, 1);
    tick();
    chk("oor_err_clear", rd_err, 0);

    // Reset while a read result is on the outputs
    rd(1, 1);
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("rst_read_valid", out_valid, 0);
    chk("rst_read_data", out_data1, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_read_rd_ready", rd_ready, 0);

    for (int i = 0; i < NC*D; i++) dat[i] = W'(8'hA0 + i);
    load_seq(-1, 5);
    for (int i = 0; i < NC*D; i++) dat[i] = W'(8'hF0 + i);
    load_seq(-1, -1);
    rd(0, 0);
    chk("reload_data1", out_data1, 16'hF4F0);

    // Randomized content then randomized read traffic against the model
    for (int i = 0; i < NC*D; i++) dat[i] = W'($urandom);
    load_seq(int'($urandom_range(0, NC*D - 1)), -1);
    hold1 = out_data1;
    hold2 = out_data2;
    for (int n = 0; n < 60; n++) begin
      int a1, a2;
      a1 = int'($urandom_range(0, D + 1));
      a2 = int'($urandom_range(0, D + 1));
      pv = ($urandom_range(0, 3) != 0);
      rd_valid = pv;
      rd_addr1 = AW'(a1);
      rd_addr2 = AW'(a2);
      if (pv) begin
        hold1 = exp_row(a1);
        hold2 = exp_row(a2);
      end
      perr = pv && (a1 >= D || a2 >= D);
      e1 = hold1;
      e2 = hold2;
      tick();
      chk("rnd_valid", out_valid, pv);
      chk("rnd_data1", out_data1, e1);
      chk("rnd_data2", out_data2, e2);
      chk("rnd_err", rd_err, perr);
    end
    rd_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
